// File: rtl/f5_pkg.sv
`default_nettype none
// ============================================================
// f5_pkg : shared types and defaults for the f5 sweep checker
// Rev 1.0
// ============================================================
package f5_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] TRUTH_DEFAULT  = 4'b0010;
    localparam int         SETTLE_DEFAULT = 1;
    localparam int         SETTLE_MAX     = 15;

    // Mismatch count tops out at the number of minterms.
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v >= 3'd4) ? v : v + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/f5_settle_cnt.sv
`default_nettype none
// ============================================================
// f5_settle_cnt : 4-bit load/decrement settle timer
// Rev 1.0
// ============================================================
module f5_settle_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       is_one
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign is_one = (cnt_q == 4'd1);

endmodule
`default_nettype wire

// File: rtl/f5_sweep_ctrl.sv
`default_nettype none
// ============================================================
// f5_sweep_ctrl : sweeps all four (x,y) minterms, compares two
//                 implementations against a truth table
// Rev 1.0
// ============================================================
module f5_sweep_ctrl
    import f5_pkg::*;
#(
    parameter logic [3:0] TRUTH  = TRUTH_DEFAULT,
    parameter int         SETTLE = SETTLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       a_in,
    input  logic       b_in,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [1:0] first_fail,
    output logic [3:0] result_vec
);

    localparam logic [3:0] C_SETTLE = SETTLE[3:0];

    state_t     state_q, state_d;
    logic [1:0] m_q, m_d;
    logic       x_q, x_d;
    logic       y_q, y_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_cnt_q, err_cnt_d;
    logic [1:0] first_fail_q, first_fail_d;
    logic [3:0] result_vec_q, result_vec_d;

    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_cnt_is_one;
    logic w_mismatch;

    f5_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_cnt_load),
        .load_val (C_SETTLE),
        .dec      (w_cnt_dec),
        .is_one   (w_cnt_is_one)
    );

    assign w_mismatch = (a_in != b_in) || (a_in != TRUTH[m_q]);

    always_comb begin
        state_d      = state_q;
        m_d          = m_q;
        x_d          = x_q;
        y_d          = y_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        first_fail_d = first_fail_q;
        result_vec_d = result_vec_q;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                x_d = 1'b0;
                y_d = 1'b0;
                if (start) begin
                    state_d      = ST_DRIVE;
                    m_d          = 2'd0;
                    err_cnt_d    = 3'd0;
                    first_fail_d = 2'd0;
                    result_vec_d = 4'd0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            ST_DRIVE: begin
                x_d        = m_q[1];
                y_d        = m_q[0];
                w_cnt_load = 1'b1;
                state_d    = (C_SETTLE != 4'd0) ? ST_WAIT : ST_SAMPLE;
            end
            ST_WAIT: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_is_one) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                result_vec_d[m_q] = a_in;
                if (w_mismatch) begin
                    err_cnt_d = sat_inc3(err_cnt_q);
                    if (err_cnt_q == 3'd0) begin
                        first_fail_d = m_q;
                    end
                end
                // Operands drop to zero on the way into DONE.
                if (m_q == 2'd3) begin
                    state_d = ST_DONE;
                    x_d     = 1'b0;
                    y_d     = 1'b0;
                end else begin
                    m_d     = m_q + 2'd1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_cnt_q == 3'd0);
                x_d     = 1'b0;
                y_d     = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            m_q          <= 2'd0;
            x_q          <= 1'b0;
            y_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= 3'd0;
            first_fail_q <= 2'd0;
            result_vec_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            m_q          <= m_d;
            x_q          <= x_d;
            y_q          <= y_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            first_fail_q <= first_fail_d;
            result_vec_q <= result_vec_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_cnt_q;
    assign first_fail = first_fail_q;
    assign result_vec = result_vec_q;

endmodule
`default_nettype wire
